// File: rtl/rob_multi.sv
// -----------------------------------------------------------------------------
// rob_multi : registered multi-lane reorder buffer
//
// Instructions enter at the tail in program order (up to DISP_W per cycle).
// Results arrive out of order, addressed by ROB index. Completed entries leave
// in order from the head (up to RET_W per cycle) and hand their destination and
// previous physical registers back to the rename / free-list logic.
//
// Ports
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   flush         : synchronous squash of every entry (beats all other activity)
//   disp_valid    : per-lane allocate request
//   disp_rd       : new destination preg per lane (lane k at [k*PREG_W +: PREG_W])
//   disp_old_rd   : previous mapping of the architectural register per lane
//   disp_ready    : at least DISP_W entries are free (from registered count)
//   disp_idx      : ROB index each lane would receive this cycle (combinational)
//   cmp_valid     : per-port completion strobe
//   cmp_idx       : index being completed on each port
//   cmp_data      : result data on each port
//   ret_valid     : per-lane retire strobe, contiguous from lane 0, one cycle wide
//   ret_rd        : retired destination preg
//   ret_old_rd    : preg to return to the free list
//   ret_data      : retired result
//   count         : occupied entries
//   empty, full   : count == 0, count == DEPTH
//
// Dispatch handshake: a lane allocates on a rising edge when its disp_valid bit
// and disp_ready are both high (and flush is low). disp_ready depends only on
// registered state, never on disp_valid, so the producer may look at it before
// deciding. When disp_ready is low the whole group is dropped; there is no
// partial allocation and the producer must hold and retry.
// -----------------------------------------------------------------------------
module rob_multi #(
    parameter int DEPTH  = 16,
    parameter int DISP_W = 3,
    parameter int RET_W  = 2,
    parameter int PREG_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic [DISP_W-1:0]                   disp_valid,
    input  logic [DISP_W*PREG_W-1:0]            disp_rd,
    input  logic [DISP_W*PREG_W-1:0]            disp_old_rd,
    output logic                                disp_ready,
    output logic [DISP_W*$clog2(DEPTH)-1:0]     disp_idx,
    input  logic [DISP_W-1:0]                   cmp_valid,
    input  logic [DISP_W*$clog2(DEPTH)-1:0]     cmp_idx,
    input  logic [DISP_W*DATA_W-1:0]            cmp_data,
    output logic [RET_W-1:0]                    ret_valid,
    output logic [RET_W*PREG_W-1:0]             ret_rd,
    output logic [RET_W*PREG_W-1:0]             ret_old_rd,
    output logic [RET_W*DATA_W-1:0]             ret_data,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                empty,
    output logic                                full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(DEPTH - DISP_W);
    localparam logic [IDX_W:0] FULL_CNT  = (IDX_W+1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]          head_q, head_d;
    logic [IDX_W-1:0]          tail_q, tail_d;
    logic [IDX_W:0]            count_q, count_d;
    logic [DEPTH-1:0]          alloc_q, alloc_d;
    logic [DEPTH-1:0]          done_q, done_d;

    logic [RET_W-1:0]          ret_valid_q, ret_valid_d;
    logic [RET_W*PREG_W-1:0]   ret_rd_q, ret_rd_d;
    logic [RET_W*PREG_W-1:0]   ret_old_rd_q, ret_old_rd_d;
    logic [RET_W*DATA_W-1:0]   ret_data_q, ret_data_d;

    // Payload storage carries no reset: alloc/done qualify every read.
    logic [PREG_W-1:0]         rd_q     [DEPTH];
    logic [PREG_W-1:0]         old_rd_q [DEPTH];
    logic [DATA_W-1:0]         data_q   [DEPTH];

    // ------------------------------------------------------------------
    // Dispatch index assignment: valid lanes take consecutive slots in lane
    // order, skipping invalid lanes. The running popcount also gives the
    // total allocated this cycle.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lane_idx [DISP_W];
    logic [IDX_W:0]   disp_cnt;
    logic             disp_fire;

    always_comb begin
        disp_cnt = '0;
        disp_idx = '0;
        for (int k = 0; k < DISP_W; k++) begin
            lane_idx[k] = tail_q + disp_cnt[IDX_W-1:0];
            disp_idx[k*IDX_W +: IDX_W] = lane_idx[k];
            disp_cnt = disp_cnt + {{IDX_W{1'b0}}, disp_valid[k]};
        end
    end

    // Conservative: a retirement on the same edge is not credited.
    assign disp_ready = (count_q <= READY_MAX);
    assign disp_fire  = disp_ready && !flush;

    // ------------------------------------------------------------------
    // Retire selection: longest done prefix starting at head, up to RET_W.
    // Reads registered done bits only, so a completion on this edge is not
    // bypassed into retirement.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] ret_slot [RET_W];
    logic [RET_W-1:0] ret_mask;
    logic [IDX_W:0]   ret_cnt;
    logic             ret_run;

    always_comb begin
        ret_mask = '0;
        ret_cnt  = '0;
        ret_run  = 1'b1;
        for (int j = 0; j < RET_W; j++) begin
            ret_slot[j] = head_q + IDX_W'(j);
            if (ret_run && alloc_q[ret_slot[j]] && done_q[ret_slot[j]]) begin
                ret_mask[j] = 1'b1;
                ret_cnt     = ret_cnt + (IDX_W+1)'(1);
            end else begin
                ret_run = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic for control bits, pointers and retire outputs
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] cidx;

    always_comb begin
        alloc_d      = alloc_q;
        done_d       = done_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        ret_valid_d  = '0;
        ret_rd_d     = ret_rd_q;
        ret_old_rd_d = ret_old_rd_q;
        ret_data_d   = ret_data_q;
        cidx         = '0;

        if (flush) begin
            // Return to the reset state; nothing retires on this edge.
            alloc_d      = '0;
            done_d       = '0;
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            ret_rd_d     = '0;
            ret_old_rd_d = '0;
            ret_data_d   = '0;
        end else begin
            // Completions: ports scanned low to high, so a later port hitting
            // the same index overwrites (matches the data write below).
            for (int k = 0; k < DISP_W; k++) begin
                cidx = cmp_idx[k*IDX_W +: IDX_W];
                if (cmp_valid[k] && alloc_q[cidx]) begin
                    done_d[cidx] = 1'b1;
                end
            end

            for (int j = 0; j < RET_W; j++) begin
                if (ret_mask[j]) begin
                    alloc_d[ret_slot[j]]             = 1'b0;
                    done_d[ret_slot[j]]              = 1'b0;
                    ret_valid_d[j]                   = 1'b1;
                    ret_rd_d[j*PREG_W +: PREG_W]     = rd_q[ret_slot[j]];
                    ret_old_rd_d[j*PREG_W +: PREG_W] = old_rd_q[ret_slot[j]];
                    ret_data_d[j*DATA_W +: DATA_W]   = data_q[ret_slot[j]];
                end
            end

            // Dispatched slots are free, so they never collide with the
            // completion or retire updates above.
            if (disp_fire) begin
                for (int k = 0; k < DISP_W; k++) begin
                    if (disp_valid[k]) begin
                        alloc_d[lane_idx[k]] = 1'b1;
                        done_d[lane_idx[k]]  = 1'b0;
                    end
                end
            end

            head_d  = head_q + ret_cnt[IDX_W-1:0];
            tail_d  = tail_q + (disp_fire ? disp_cnt[IDX_W-1:0] : '0);
            count_d = count_q + (disp_fire ? disp_cnt : '0) - ret_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            alloc_q      <= '0;
            done_q       <= '0;
            ret_valid_q  <= '0;
            ret_rd_q     <= '0;
            ret_old_rd_q <= '0;
            ret_data_q   <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            alloc_q      <= alloc_d;
            done_q       <= done_d;
            ret_valid_q  <= ret_valid_d;
            ret_rd_q     <= ret_rd_d;
            ret_old_rd_q <= ret_old_rd_d;
            ret_data_q   <= ret_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Payload storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (disp_fire) begin
            for (int k = 0; k < DISP_W; k++) begin
                if (disp_valid[k]) begin
                    rd_q[lane_idx[k]]     <= disp_rd[k*PREG_W +: PREG_W];
                    old_rd_q[lane_idx[k]] <= disp_old_rd[k*PREG_W +: PREG_W];
                end
            end
        end
        if (!flush) begin
            // Last write in port order wins for duplicate indices.
            for (int k = 0; k < DISP_W; k++) begin
                if (cmp_valid[k] && alloc_q[cmp_idx[k*IDX_W +: IDX_W]]) begin
                    data_q[cmp_idx[k*IDX_W +: IDX_W]] <= cmp_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ret_valid  = ret_valid_q;
    assign ret_rd     = ret_rd_q;
    assign ret_old_rd = ret_old_rd_q;
    assign ret_data   = ret_data_q;
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_CNT);

endmodule

// File: tb/tb_rob_multi.sv
// -----------------------------------------------------------------------------
// tb_rob_multi : directed, table-driven bench for rob_multi (default params)
// -----------------------------------------------------------------------------
module tb_rob_multi;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        flush;
    logic [2:0]  disp_valid;
    logic [17:0] disp_rd;
    logic [17:0] disp_old_rd;
    logic        disp_ready;
    logic [11:0] disp_idx;
    logic [2:0]  cmp_valid;
    logic [11:0] cmp_idx;
    logic [95:0] cmp_data;
    logic [1:0]  ret_valid;
    logic [11:0] ret_rd;
    logic [11:0] ret_old_rd;
    logic [63:0] ret_data;
    logic [4:0]  count;
    logic        empty;
    logic        full;

    rob_multi dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_rd    (disp_rd),
        .disp_old_rd(disp_old_rd),
        .disp_ready (disp_ready),
        .disp_idx   (disp_idx),
        .cmp_valid  (cmp_valid),
        .cmp_idx    (cmp_idx),
        .cmp_data   (cmp_data),
        .ret_valid  (ret_valid),
        .ret_rd     (ret_rd),
        .ret_old_rd (ret_old_rd),
        .ret_data   (ret_data),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int vi, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", nm, vi, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [2:0]  dv;
        logic [17:0] rd;
        logic [17:0] old;
        logic [2:0]  cv;
        logic [11:0] ci;
        logic [95:0] cd;
        logic        fl;
        logic        chk_idx;
        logic [11:0] e_idx;
        logic [4:0]  e_count;
        logic [1:0]  e_rv;
        logic [11:0] e_rrd;
        logic [11:0] e_rold;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t v;
    vec_t tbl[$];

    task automatic nv();
        v = '0;
    endtask

    task automatic dsp(input logic [2:0] dv,
                       input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2,
                       input logic [5:0] o0, input logic [5:0] o1, input logic [5:0] o2,
                       input logic [3:0] i0, input logic [3:0] i1, input logic [3:0] i2);
        v.dv      = dv;
        v.rd      = {r2, r1, r0};
        v.old     = {o2, o1, o0};
        v.chk_idx = 1'b1;
        v.e_idx   = {i2, i1, i0};
    endtask

    task automatic cmpl(input logic [2:0] cv,
                        input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        v.cv = cv;
        v.ci = {c2, c1, c0};
        v.cd = {d2, d1, d0};
    endtask

    task automatic ex(input logic [4:0] cnt, input logic [1:0] rv);
        v.e_count = cnt;
        v.e_rv    = rv;
    endtask

    task automatic rl(input int lane, input logic [5:0] r, input logic [5:0] o, input logic [31:0] d);
        if (lane == 0) begin
            v.e_rrd[5:0]    = r;
            v.e_rold[5:0]   = o;
            v.e_rdata[31:0] = d;
        end else begin
            v.e_rrd[11:6]    = r;
            v.e_rold[11:6]   = o;
            v.e_rdata[63:32] = d;
        end
    endtask

    task automatic push();
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        disp_valid  = '0;
        disp_rd     = '0;
        disp_old_rd = '0;
        cmp_valid   = '0;
        cmp_idx     = '0;
        cmp_data    = '0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    // ---------------- main test ----------------
    initial begin
        vec_t c;
        logic [4:0] ec;

        rst_n = 1'b0;
        idle_inputs();

        // Build table
        // basic dispatch and in-order retirement of out-of-order completions
        nv(); dsp(3'b111, 10, 11, 12, 1, 2, 3, 0, 1, 2); ex(3, 2'b00); push();
        nv(); cmpl(3'b001, 1, 0, 0, 32'h111, 0, 0); ex(3, 2'b00); push();
        nv(); cmpl(3'b010, 0, 0, 0, 0, 32'h100, 0); ex(3, 2'b00); push();
        nv(); ex(1, 2'b11); rl(0, 10, 1, 32'h100); rl(1, 11, 2, 32'h111); push();
        nv(); cmpl(3'b100, 0, 0, 2, 0, 0, 32'h122); ex(1, 2'b00); push();
        nv(); ex(0, 2'b01); rl(0, 12, 3, 32'h122); push();
        // sparse lanes
        nv(); dsp(3'b011, 20, 21, 0, 4, 5, 0, 3, 4, 5); ex(2, 2'b00); push();
        nv(); dsp(3'b101, 22, 0, 23, 6, 0, 7, 5, 6, 6); ex(4, 2'b00); push();
        // fill, wrap inside one dispatch group
        nv(); dsp(3'b111, 39, 40, 41, 7, 8, 9, 7, 8, 9); ex(7, 2'b00); push();
        nv(); dsp(3'b111, 42, 43, 44, 10, 11, 12, 10, 11, 12); ex(10, 2'b00); push();
        nv(); dsp(3'b011, 45, 46, 0, 13, 14, 0, 13, 14, 15); ex(12, 2'b00); push();
        nv(); dsp(3'b011, 47, 32, 0, 15, 0, 0, 15, 0, 1); ex(14, 2'b00); push();
        // backpressure: whole group dropped
        nv(); dsp(3'b111, 60, 61, 62, 0, 0, 0, 1, 2, 3); ex(14, 2'b00); push();
        nv(); cmpl(3'b011, 3, 4, 0, 32'hA3, 32'hA4, 0); ex(14, 2'b00); push();
        nv(); ex(12, 2'b11); rl(0, 20, 4, 32'hA3); rl(1, 21, 5, 32'hA4); push();
        nv(); dsp(3'b001, 33, 0, 0, 1, 0, 0, 1, 2, 3); ex(13, 2'b00); push();
        nv(); dsp(3'b111, 34, 35, 36, 2, 3, 4, 2, 3, 4); ex(16, 2'b00); push();
        // drain some
        nv(); cmpl(3'b011, 5, 6, 0, 32'hB5, 32'hB6, 0); ex(16, 2'b00); push();
        nv(); ex(14, 2'b11); rl(0, 22, 6, 32'hB5); rl(1, 23, 7, 32'hB6); push();
        nv(); cmpl(3'b011, 7, 8, 0, 32'hC7, 32'hC8, 0); ex(14, 2'b00); push();
        nv(); ex(12, 2'b11); rl(0, 39, 7, 32'hC7); rl(1, 40, 8, 32'hC8); push();
        // completion to a freed slot is ignored
        nv(); cmpl(3'b001, 5, 0, 0, 32'hDEAD, 0, 0); ex(12, 2'b00); push();
        // same index on ports 0 and 2: port 2 wins
        nv(); cmpl(3'b111, 9, 10, 9, 32'hAAAA, 32'hCA, 32'hBBBB); ex(12, 2'b00); push();
        nv(); ex(10, 2'b11); rl(0, 41, 9, 32'hBBBB); rl(1, 42, 10, 32'hCA); push();
        nv(); cmpl(3'b011, 11, 12, 0, 32'hE1, 32'hE2, 0); ex(10, 2'b00); push();
        nv(); cmpl(3'b011, 13, 14, 0, 32'hE3, 32'hE4, 0); ex(8, 2'b11);
              rl(0, 43, 11, 32'hE1); rl(1, 44, 12, 32'hE2); push();
        nv(); cmpl(3'b001, 15, 0, 0, 32'hF15, 0, 0); ex(6, 2'b11);
              rl(0, 45, 13, 32'hE3); rl(1, 46, 14, 32'hE4); push();
        // flush with head retirable, plus dispatch and completion on the same edge
        nv(); v.fl = 1'b1; dsp(3'b111, 1, 2, 3, 1, 2, 3, 5, 6, 7);
              cmpl(3'b001, 0, 0, 0, 32'h77, 0, 0); ex(0, 2'b00); push();
        nv(); ex(0, 2'b00); push();
        nv(); ex(0, 2'b00); push();
        nv(); dsp(3'b001, 50, 0, 0, 1, 0, 0, 0, 1, 2); ex(1, 2'b00); push();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", -1, count, 0);
        chk("rst_empty", -1, empty, 1);
        chk("rst_full", -1, full, 0);
        chk("rst_ready", -1, disp_ready, 1);
        chk("rst_ret_valid", -1, ret_valid, 0);
        chk("rst_ret_rd", -1, ret_rd, 0);
        rst_n = 1'b1;

        // Table loop
        for (int i = 0; i < tbl.size(); i++) begin
            c = tbl[i];
            @(negedge clk);
            flush       = c.fl;
            disp_valid  = c.dv;
            disp_rd     = c.rd;
            disp_old_rd = c.old;
            cmp_valid   = c.cv;
            cmp_idx     = c.ci;
            cmp_data    = c.cd;
            #1;
            if (c.chk_idx) begin
                for (int k = 0; k < 3; k++) begin
                    if (c.dv[k]) chk("disp_idx", i, disp_idx[k*4 +: 4], c.e_idx[k*4 +: 4]);
                end
            end
            @(posedge clk);
            #1;
            ec = c.e_count;
            chk("count", i, count, ec);
            chk("ret_valid", i, ret_valid, c.e_rv);
            chk("disp_ready", i, disp_ready, (ec <= 5'd13));
            chk("empty", i, empty, (ec == 5'd0));
            chk("full", i, full, (ec == 5'd16));
            for (int j = 0; j < 2; j++) begin
                if (c.e_rv[j]) begin
                    chk("ret_rd", i, ret_rd[j*6 +: 6], c.e_rrd[j*6 +: 6]);
                    chk("ret_old_rd", i, ret_old_rd[j*6 +: 6], c.e_rold[j*6 +: 6]);
                    chk("ret_data", i, ret_data[j*32 +: 32], c.e_rdata[j*32 +: 32]);
                end
            end
        end

        // Hand sequence: hold of non-retiring lanes, then async reset mid-cycle.
        // State here: head 0, tail 1, entry 0 = rd 50 / old 1.
        @(negedge clk);
        idle_inputs();
        disp_valid  = 3'b111;
        disp_rd     = {6'd53, 6'd52, 6'd51};
        disp_old_rd = {6'd4, 6'd3, 6'd2};
        #1;
        chk("h_disp_idx", 100, disp_idx, {4'd3, 4'd2, 4'd1});
        @(posedge clk); #1;
        chk("h_count4", 100, count, 4);

        @(negedge clk);
        idle_inputs();
        cmp_valid = 3'b011;
        cmp_idx   = {4'd0, 4'd1, 4'd0};
        cmp_data  = {32'h0, 32'h51, 32'h50};
        @(posedge clk); #1;
        chk("h_no_bypass", 101, ret_valid, 2'b00);

        @(negedge clk);
        idle_inputs();
        cmp_valid = 3'b001;
        cmp_idx   = {4'd0, 4'd0, 4'd2};
        cmp_data  = {32'h0, 32'h0, 32'h52};
        @(posedge clk); #1;
        chk("h_rv11", 102, ret_valid, 2'b11);
        chk("h_rd_pair", 102, ret_rd, {6'd51, 6'd50});
        chk("h_data_pair", 102, ret_data, {32'h51, 32'h50});
        chk("h_count2", 102, count, 2);

        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        chk("h_rv01", 103, ret_valid, 2'b01);
        chk("h_rd_hold", 103, ret_rd, {6'd51, 6'd52});
        chk("h_old_hold", 103, ret_old_rd, {6'd2, 6'd3});
        chk("h_count1", 103, count, 1);

        @(negedge clk);
        disp_valid  = 3'b111;
        disp_rd     = {6'd56, 6'd55, 6'd54};
        disp_old_rd = {6'd7, 6'd6, 6'd5};
        @(posedge clk); #1;
        chk("h_count4b", 104, count, 4);

        @(negedge clk);
        idle_inputs();
        cmp_valid = 3'b001;
        cmp_idx   = {4'd0, 4'd0, 4'd3};
        cmp_data  = {32'h0, 32'h0, 32'h53};
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("a_count", 105, count, 0);
        chk("a_empty", 105, empty, 1);
        chk("a_ready", 105, disp_ready, 1);
        chk("a_ret_valid", 105, ret_valid, 0);
        chk("a_ret_rd", 105, ret_rd, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("a_ret_valid2", 106, ret_valid, 0);
        chk("a_count2", 106, count, 0);

        @(negedge clk);
        disp_valid  = 3'b001;
        disp_rd     = {6'd0, 6'd0, 6'd57};
        disp_old_rd = {6'd0, 6'd0, 6'd8};
        #1;
        chk("a_disp_idx", 107, disp_idx[3:0], 0);
        @(posedge clk); #1;
        chk("a_count3", 107, count, 1);
        chk("a_ret_valid3", 107, ret_valid, 0);

        @(negedge clk);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
